// File: rtl/lcd_frame_dma.sv
// AXI4 read-DMA frame fetcher into a show-ahead pixel FIFO; a pushed beat is visible at the head one cycle later.
// Bursts are issued only into reserved FIFO space, so RREADY never drops mid-burst; the consumer paces via fifo_rd.
module lcd_frame_dma #(
    parameter int DATA_W       = 32,
    parameter int BURST_LEN    = 20,
    parameter int FRAME_BURSTS = 1920,
    parameter int FIFO_DEPTH   = 1024,
    parameter int LVL_W        = 11
) (
    input  logic              S_AXI_ACLK,
    input  logic              M_AXI_ARESETN,
    input  logic              frame_req,
    input  logic [31:0]       frame_address,
    input  logic              loop_en,
    input  logic              abort,
    output logic [31:0]       M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic [3:0]        M_AXI_ARCACHE,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    input  logic              fifo_rd,
    output logic              fifo_valid,
    output logic [DATA_W-1:0] fifo_data,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              busy,
    output logic              frame_done,
    output logic              rresp_err
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int BC_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam logic [31:0]     BURST_BYTES = 32'(BURST_LEN * (DATA_W / 8));
    localparam logic [BC_W-1:0] LAST_BURST  = BC_W'(FRAME_BURSTS - 1);
    localparam logic [LVL_W:0]  DEPTH_V     = (LVL_W + 1)'(FIFO_DEPTH);
    localparam logic [LVL_W:0]  BURST_V     = (LVL_W + 1)'(BURST_LEN);
    localparam logic [LVL_W-1:0] BURST_LV   = LVL_W'(BURST_LEN);

    typedef enum logic [2:0] {S_IDLE, S_WAIT_SPACE, S_ADDR, S_DATA, S_FLUSH} state_t;

    state_t            state;
    logic [31:0]       base;
    logic [31:0]       next_addr;
    logic [BC_W-1:0]   burst_cnt;
    logic [LVL_W-1:0]  reserved;
    logic              abort_pend;
    logic [LVL_W-1:0]  wr_ptr;
    logic [LVL_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [LVL_W:0]    free_words;
    logic              push;
    logic              pop;
    logic              abort_any;
    logic              grant;

    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DATA_W / 8));
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARCACHE = 4'b0011;

    assign push       = M_AXI_RVALID & M_AXI_RREADY;
    assign pop        = fifo_rd & fifo_valid;
    assign abort_any  = abort | abort_pend;
    assign free_words = DEPTH_V - {1'b0, fifo_level} - {1'b0, reserved};
    assign grant      = (state == S_WAIT_SPACE) && !abort_any && (free_words >= BURST_V);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge S_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= S_IDLE;
            base          <= '0;
            next_addr     <= '0;
            burst_cnt     <= '0;
            reserved      <= '0;
            abort_pend    <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            frame_done    <= 1'b0;
            rresp_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (push && M_AXI_RRESP != 2'b00)
                rresp_err <= 1'b1;
            if (abort && state != S_IDLE && state != S_FLUSH)
                abort_pend <= 1'b1;
            // Space is claimed at AR time and handed back one word per pushed beat.
            if (grant)
                reserved <= reserved + BURST_LV;
            else if (push)
                reserved <= reserved - LVL_W'(1);

            case (state)
                S_IDLE: begin
                    if (frame_req) begin
                        base       <= frame_address;
                        next_addr  <= frame_address;
                        burst_cnt  <= '0;
                        rresp_err  <= 1'b0;
                        abort_pend <= 1'b0;
                        state      <= S_WAIT_SPACE;
                    end
                end
                S_WAIT_SPACE: begin
                    if (abort_any) begin
                        abort_pend <= 1'b0;
                        state      <= S_FLUSH;
                    end else if (grant) begin
                        M_AXI_ARVALID <= 1'b1;
                        M_AXI_ARADDR  <= next_addr;
                        state         <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (push && M_AXI_RLAST) begin
                        M_AXI_RREADY <= 1'b0;
                        if (abort_any) begin
                            abort_pend <= 1'b0;
                            state      <= S_FLUSH;
                        end else if (burst_cnt == LAST_BURST) begin
                            frame_done <= 1'b1;
                            if (loop_en) begin
                                burst_cnt <= '0;
                                next_addr <= base;
                                state     <= S_WAIT_SPACE;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + BC_W'(1);
                            next_addr <= next_addr + BURST_BYTES;
                            state     <= S_WAIT_SPACE;
                        end
                    end
                end
                S_FLUSH: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pointers carry one extra wrap bit so full and empty differ and level is a plain subtraction.
    always_ff @(posedge S_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (state == S_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + LVL_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + LVL_W'(1);
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= M_AXI_RDATA;
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_valid = (wr_ptr != rd_ptr);
    assign fifo_data  = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_lcd_frame_dma.sv
// Directed bench for lcd_frame_dma with a 4-beat AXI read slave model and a pacing consumer.
module tb_lcd_frame_dma;

    logic        clk;
    logic        arst_n;
    logic        frame_req;
    logic [31:0] frame_address;
    logic        loop_en;
    logic        abort;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  arcache;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        fifo_rd;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        frame_done;
    logic        rresp_err;

    lcd_frame_dma #(
        .DATA_W(32), .BURST_LEN(4), .FRAME_BURSTS(3), .FIFO_DEPTH(8), .LVL_W(4)
    ) dut (
        .S_AXI_ACLK(clk), .M_AXI_ARESETN(arst_n),
        .frame_req(frame_req), .frame_address(frame_address), .loop_en(loop_en), .abort(abort),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARCACHE(arcache),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .fifo_rd(fifo_rd), .fifo_valid(fifo_valid), .fifo_data(fifo_data),
        .fifo_level(fifo_level), .busy(busy), .frame_done(frame_done), .rresp_err(rresp_err)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] ar0;
        logic [31:0] ar1;
        logic [31:0] ar2;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] exp_ar [3];

    int          errors;
    int          checks;
    int          ar_stall;
    int          err_at;
    int          srv_cnt;
    int          pop_target;
    logic        pop_all;
    logic        force_rd;
    logic [31:0] ar_log [$];
    logic [7:0]  arlen_log [$];
    logic [31:0] out_q [$];
    int          done_beats [$];
    int          beat_cnt;
    int          done_cnt;

    int          a0, o0, d0, b0, n;
    logic [31:0] hold_addr;
    logic        stable;
    int          st;
    logic [31:0] cur_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    // AXI read slave: every beat carries its own byte address as data.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rresp = 2'b00;
        srv_cnt = 0;
        forever begin
            @(negedge clk);
            if (arvalid) begin
                st = ar_stall;
                for (int w = 0; w < st; w++) @(negedge clk);
                arready  = 1'b1;
                cur_addr = araddr;
                @(negedge clk);
                arready = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    rvalid = 1'b1;
                    rdata  = cur_addr + 32'(4 * b);
                    rlast  = (b == 3);
                    rresp  = (srv_cnt == err_at) ? 2'b10 : 2'b00;
                    @(negedge clk);
                    srv_cnt++;
                end
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end
        end
    end

    initial begin
        fifo_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_valid && (pop_all || out_q.size() < pop_target)) begin
                out_q.push_back(fifo_data);
                fifo_rd = 1'b1;
            end else begin
                fifo_rd = force_rd;
            end
        end
    end

    initial begin
        beat_cnt = 0;
        done_cnt = 0;
        forever begin
            @(posedge clk);
            if (arst_n) begin
                if (arvalid && arready) begin
                    ar_log.push_back(araddr);
                    arlen_log.push_back(arlen);
                end
                if (rvalid && rready) beat_cnt++;
                if (frame_done) begin
                    done_cnt++;
                    done_beats.push_back(beat_cnt);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_frame(input logic [31:0] a);
        @(negedge clk);
        frame_address = a;
        frame_req     = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic snap();
        a0 = ar_log.size();
        o0 = out_q.size();
        d0 = done_cnt;
        b0 = beat_cnt;
    endtask

    task automatic chk_words(input string nm, input logic [31:0] base, input int cnt);
        chk({nm, "_count"}, 32'(out_q.size() - o0), 32'(cnt));
        if (out_q.size() >= o0 + cnt)
            for (int i = 0; i < cnt; i++)
                chk($sformatf("%s_w%0d", nm, i), out_q[o0 + i], base + 32'(4 * i));
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1010, 32'h0000_1020};
        vecs[1] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0020};
        vecs[2] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0010};
        vecs[3] = '{32'h8000_0040, 32'h8000_0040, 32'h8000_0050, 32'h8000_0060};

        errors = 0; checks = 0;
        frame_req = 1'b0; frame_address = '0; loop_en = 1'b0; abort = 1'b0;
        ar_stall = 0; err_at = -1; pop_all = 1'b0; pop_target = 0; force_rd = 1'b0;

        arst_n = 1'b1;
        #2 arst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd3);
        chk("rst_arsize", 32'(arsize), 32'd2);
        chk("rst_arburst", 32'(arburst), 32'd1);
        chk("rst_arcache", 32'(arcache), 32'd3);
        chk("rst_fifo_valid", 32'(fifo_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_rresp_err", 32'(rresp_err), 32'd0);
        arst_n = 1'b1;

        // Pops on an empty FIFO must not underflow the level.
        force_rd = 1'b1;
        repeat (3) @(negedge clk);
        force_rd = 1'b0;
        chk("empty_pop_level", 32'(fifo_level), 32'd0);
        chk("empty_pop_valid", 32'(fifo_valid), 32'd0);

        // Full frames with an always-ready consumer, one per table row.
        pop_all = 1'b1;
        for (int v = 0; v < 4; v++) begin
            snap();
            exp_ar[0] = vecs[v].ar0; exp_ar[1] = vecs[v].ar1; exp_ar[2] = vecs[v].ar2;
            start_frame(vecs[v].base);
            wait_idle($sformatf("t1_v%0d_idle", v), 200);
            repeat (4) @(negedge clk);
            chk($sformatf("t1_v%0d_ar_count", v), 32'(ar_log.size() - a0), 32'd3);
            for (int k = 0; k < 3; k++)
                if (ar_log.size() > a0 + k)
                    chk($sformatf("t1_v%0d_ar%0d", v, k), ar_log[a0 + k], exp_ar[k]);
            if (arlen_log.size() > a0)
                chk($sformatf("t1_v%0d_arlen", v), 32'(arlen_log[a0]), 32'd3);
            chk($sformatf("t1_v%0d_count", v), 32'(out_q.size() - o0), 32'd12);
            if (out_q.size() >= o0 + 12)
                for (int i = 0; i < 12; i++)
                    chk($sformatf("t1_v%0d_w%0d", v, i), out_q[o0 + i], exp_ar[i / 4] + 32'(4 * (i % 4)));
            chk($sformatf("t1_v%0d_done", v), 32'(done_cnt - d0), 32'd1);
            chk($sformatf("t1_v%0d_level", v), 32'(fifo_level), 32'd0);
        end

        // Stalled consumer: reservation limits the number of outstanding bursts.
        pop_all = 1'b0; pop_target = out_q.size();
        snap();
        start_frame(32'h0000_A000);
        repeat (40) @(negedge clk);
        chk("t2_ar_count_full", 32'(ar_log.size() - a0), 32'd2);
        chk("t2_level_full", 32'(fifo_level), 32'd8);
        chk("t2_head", fifo_data, 32'h0000_A000);
        chk("t2_busy", 32'(busy), 32'd1);
        pop_target = out_q.size() + 1;
        repeat (20) @(negedge clk);
        chk("t2_ar_count_pop1", 32'(ar_log.size() - a0), 32'd2);
        chk("t2_level_pop1", 32'(fifo_level), 32'd7);
        pop_target = out_q.size() + 3;
        repeat (30) @(negedge clk);
        chk("t2_ar_count_pop4", 32'(ar_log.size() - a0), 32'd3);
        chk("t2_level_pop4", 32'(fifo_level), 32'd8);
        pop_all = 1'b1;
        wait_idle("t2_idle", 200);
        repeat (12) @(negedge clk);
        chk_words("t2", 32'h0000_A000, 12);
        chk("t2_done", 32'(done_cnt - d0), 32'd1);

        // Looped refresh, then drop loop_en mid-frame.
        snap();
        loop_en = 1'b1;
        start_frame(32'h0000_2000);
        n = 0;
        while (ar_log.size() < a0 + 4 && n < 200) begin @(negedge clk); n++; end
        chk("t3_fourth_ar_seen", 32'(ar_log.size() - a0), 32'd4);
        if (ar_log.size() >= a0 + 4)
            chk("t3_wrap_to_base", ar_log[a0 + 3], 32'h0000_2000);
        chk("t3_done_first", 32'(done_cnt - d0), 32'd1);
        if (done_beats.size() > d0)
            chk("t3_done_at_12", 32'(done_beats[d0] - b0), 32'd12);
        loop_en = 1'b0;
        wait_idle("t3_idle", 300);
        repeat (10) @(negedge clk);
        chk("t3_ar_total", 32'(ar_log.size() - a0), 32'd6);
        chk("t3_done_total", 32'(done_cnt - d0), 32'd2);
        if (done_beats.size() > d0 + 1)
            chk("t3_done_at_24", 32'(done_beats[d0 + 1] - b0), 32'd24);

        // Abort on the second beat of the first burst.
        pop_all = 1'b0; pop_target = out_q.size();
        snap();
        start_frame(32'h0000_3000);
        n = 0;
        while (beat_cnt - b0 < 1 && n < 100) begin @(negedge clk); n++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t4_idle", 100);
        repeat (10) @(negedge clk);
        chk("t4_beats", 32'(beat_cnt - b0), 32'd4);
        chk("t4_ar_count", 32'(ar_log.size() - a0), 32'd1);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t4_level", 32'(fifo_level), 32'd0);
        chk("t4_valid", 32'(fifo_valid), 32'd0);
        chk("t4_rready", 32'(rready), 32'd0);

        // Abort while waiting for space flushes without another burst.
        snap();
        start_frame(32'h0000_4000);
        repeat (40) @(negedge clk);
        chk("t4b_level_full", 32'(fifo_level), 32'd8);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t4b_idle", 10);
        chk("t4b_level", 32'(fifo_level), 32'd0);
        chk("t4b_ar_count", 32'(ar_log.size() - a0), 32'd2);
        chk("t4b_no_done", 32'(done_cnt - d0), 32'd0);

        // SLVERR on the fifth beat: sticky flag, frame still completes.
        pop_all = 1'b1;
        snap();
        err_at = srv_cnt + 4;
        start_frame(32'h0000_5000);
        n = 0;
        while (beat_cnt - b0 < 6 && n < 100) begin @(negedge clk); n++; end
        chk("t5_err_set", 32'(rresp_err), 32'd1);
        wait_idle("t5_idle", 200);
        repeat (4) @(negedge clk);
        chk("t5_err_sticky", 32'(rresp_err), 32'd1);
        chk("t5_done", 32'(done_cnt - d0), 32'd1);
        chk_words("t5", 32'h0000_5000, 12);
        err_at = -1;
        start_frame(32'h0000_5000);
        chk("t5_err_cleared", 32'(rresp_err), 32'd0);
        wait_idle("t5_idle2", 200);
        chk("t5_err_clean_frame", 32'(rresp_err), 32'd0);

        // Slow ARREADY plus an ignored frame_req while busy.
        repeat (4) @(negedge clk);
        snap();
        ar_stall = 10;
        start_frame(32'h0000_6000);
        n = 0;
        while (!arvalid && n < 20) begin @(negedge clk); n++; end
        hold_addr = araddr;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!arvalid || araddr != hold_addr) stable = 1'b0;
            if (i == 3) begin frame_req = 1'b1; frame_address = 32'h0000_9000; end
            if (i == 4) frame_req = 1'b0;
        end
        ar_stall = 0;
        chk("t6_first_addr", hold_addr, 32'h0000_6000);
        chk("t6_ar_stable", 32'(stable), 32'd1);
        wait_idle("t6_idle", 300);
        repeat (10) @(negedge clk);
        chk("t6_ar_count", 32'(ar_log.size() - a0), 32'd3);
        if (ar_log.size() >= a0 + 3) begin
            chk("t6_ar1", ar_log[a0 + 1], 32'h0000_6010);
            chk("t6_ar2", ar_log[a0 + 2], 32'h0000_6020);
        end
        chk_words("t6", 32'h0000_6000, 12);
        chk("t6_still_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
